// File: rtl/multdiv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multdiv_pkg: shared types and constants for the mult/div sequencer       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_MULT = 2'd1,
    RUN_DIV  = 2'd2
  } state_t;

  localparam int MULT_LAT_DEF = 16;
  localparam int DIV_LAT_DEF  = 32;
  localparam int COUNT_W      = 6;

endpackage
`default_nettype wire

// File: rtl/multdiv_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multdiv_counter: iteration counter, synchronous clear beats increment    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module multdiv_counter
  import multdiv_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               inc,
  output logic [COUNT_W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/multdiv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multdiv_sequencer: sequences shared iterative multiplier/divider         |
// | Optional: MULTDIV_DIV0_FAST_EN (divide-by-zero answered from IDLE)       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_mult,
  input  logic               ctrl_div,
  input  logic [31:0]        data_a,
  input  logic [31:0]        data_b,
  output logic [31:0]        unit_a,
  output logic [31:0]        unit_b,
  output logic [COUNT_W-1:0] count,
  output logic               mult_sel,
  input  logic [31:0]        mult_result,
  input  logic               mult_overflow,
  input  logic [31:0]        div_result,
  input  logic               div_exception,
  output logic               busy,
  output logic               result_rdy,
  output logic [31:0]        result,
  output logic               exception
);

  localparam logic [COUNT_W-1:0] MULT_LAT_C = COUNT_W'(MULT_LAT);
  localparam logic [COUNT_W-1:0] DIV_LAT_C  = COUNT_W'(DIV_LAT);

  state_t state, next_state;
  logic   cnt_clear, cnt_inc;
  logic   capture, load, div0_fast;
  logic   div_by_zero;

`ifdef MULTDIV_DIV0_FAST_EN
  assign div_by_zero = (data_b == 32'd0);
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    capture    = 1'b0;
    load       = 1'b0;
    div0_fast  = 1'b0;

    case (state)
      RUN_MULT, RUN_DIV: begin
        if ((state == RUN_MULT && count == MULT_LAT_C) ||
            (state == RUN_DIV  && count == DIV_LAT_C)) begin
          capture    = 1'b1;
          cnt_clear  = 1'b1;
          next_state = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: cnt_clear = 1'b1;
    endcase

    // A new request overrides (aborts) whatever is in flight; multiply wins ties.
    if (ctrl_mult) begin
      load       = 1'b1;
      cnt_clear  = 1'b1;
      next_state = RUN_MULT;
    end else if (ctrl_div) begin
      cnt_clear = 1'b1;
      if (div_by_zero) begin
        div0_fast  = 1'b1;
        next_state = IDLE;
      end else begin
        load       = 1'b1;
        next_state = RUN_DIV;
      end
    end
  end

  multdiv_counter u_counter (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      unit_a     <= '0;
      unit_b     <= '0;
      mult_sel   <= 1'b0;
      result     <= '0;
      exception  <= 1'b0;
      result_rdy <= 1'b0;
    end else begin
      result_rdy <= capture | div0_fast;
      if (load) begin
        unit_a   <= data_a;
        unit_b   <= data_b;
        mult_sel <= ctrl_mult;
      end
      if (div0_fast) begin
        result    <= '0;
        exception <= 1'b1;
      end else if (capture) begin
        if (state == RUN_MULT) begin
          result    <= mult_result;
          exception <= mult_overflow;
        end else begin
          result    <= div_exception ? 32'd0 : div_result;
          exception <= div_exception;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multdiv_sequencer: directed vector bench with behavioural unit model  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_mult, ctrl_div;
  logic [31:0] data_a, data_b;
  logic [31:0] unit_a, unit_b;
  logic [5:0]  count;
  logic        mult_sel;
  logic [31:0] mult_result, div_result;
  logic        mult_overflow, div_exception;
  logic        busy, result_rdy;
  logic [31:0] result;
  logic        exception;
  logic        ovf_force;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Behavioural stand-ins for the iterative units.
  assign mult_result   = unit_a * unit_b;
  assign mult_overflow = ovf_force;
  assign div_result    = (unit_b != 0) ? unit_a / unit_b : 32'hDEADBEEF;
  assign div_exception = (unit_b == 0);

  multdiv_sequencer dut (
    .clock(clock), .reset(reset), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
    .data_a(data_a), .data_b(data_b), .unit_a(unit_a), .unit_b(unit_b),
    .count(count), .mult_sel(mult_sel), .mult_result(mult_result),
    .mult_overflow(mult_overflow), .div_result(div_result),
    .div_exception(div_exception), .busy(busy), .result_rdy(result_rdy),
    .result(result), .exception(exception)
  );

  typedef struct {
    logic        is_mult;
    logic [31:0] a;
    logic [31:0] b;
    logic        ovf;
    logic [31:0] exp_result;
    logic        exp_exc;
    int          exp_edges;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Pulse ctrl for one sampled edge (E0); returns at the negedge after E0.
  task automatic pulse(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    ctrl_mult = m; ctrl_div = d; data_a = a; data_b = b;
    tick();
    ctrl_mult = 1'b0; ctrl_div = 1'b0;
  endtask

  // Edges since E0 until result_rdy is observed, bounded.
  task automatic wait_rdy(input int start, output int edges, output int maxc);
    edges = start;
    maxc  = 0;
    while (!result_rdy && edges < 200) begin
      if (int'(count) > maxc) maxc = int'(count);
      tick();
      edges++;
    end
  endtask

  int edges, maxc, rdy_seen;

  initial begin
    reset = 1'b1; ctrl_mult = 1'b0; ctrl_div = 1'b0;
    data_a = '0; data_b = '0; ovf_force = 1'b0;

    vecs[0] = '{1'b1, 32'd7,          32'd6,          1'b0, 32'd42,         1'b0, 18};
    vecs[1] = '{1'b0, 32'd100,        32'd7,          1'b0, 32'd14,         1'b0, 34};
    vecs[2] = '{1'b1, 32'h40000000,   32'd2,          1'b1, 32'h80000000,   1'b1, 18};
`ifdef MULTDIV_DIV0_FAST_EN
    vecs[3] = '{1'b0, 32'd5,          32'd0,          1'b0, 32'd0,          1'b1, 1};
`else
    vecs[3] = '{1'b0, 32'd5,          32'd0,          1'b0, 32'd0,          1'b1, 34};
`endif
    vecs[4] = '{1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'd1,          1'b0, 18};
    vecs[5] = '{1'b0, 32'hFFFFFFFF,   32'd16,         1'b0, 32'h0FFFFFFF,   1'b0, 34};

    repeat (3) tick();
    reset = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_count", {26'd0, count}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_exc", {31'd0, exception}, 32'd0);
    chk("reset_rdy", {31'd0, result_rdy}, 32'd0);
    chk("reset_unit_a", unit_a, 32'd0);
    chk("reset_mult_sel", {31'd0, mult_sel}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      ovf_force = vecs[i].ovf;
      pulse(vecs[i].is_mult, !vecs[i].is_mult, vecs[i].a, vecs[i].b);
      if (vecs[i].exp_edges > 1) begin
        chk($sformatf("v%0d_busy_start", i), {31'd0, busy}, 32'd1);
        chk($sformatf("v%0d_count_start", i), {26'd0, count}, 32'd0);
        chk($sformatf("v%0d_mult_sel", i), {31'd0, mult_sel}, {31'd0, vecs[i].is_mult});
      end else begin
        chk($sformatf("v%0d_busy_fast", i), {31'd0, busy}, 32'd0);
      end
      wait_rdy(1, edges, maxc);
      chk($sformatf("v%0d_latency", i), edges, vecs[i].exp_edges);
      if (vecs[i].exp_edges > 1)
        chk($sformatf("v%0d_max_count", i), maxc, vecs[i].is_mult ? 16 : 32);
      chk($sformatf("v%0d_result", i), result, vecs[i].exp_result);
      chk($sformatf("v%0d_exc", i), {31'd0, exception}, {31'd0, vecs[i].exp_exc});
      chk($sformatf("v%0d_busy_end", i), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_count_end", i), {26'd0, count}, 32'd0);
      tick();
      chk($sformatf("v%0d_rdy_once", i), {31'd0, result_rdy}, 32'd0);
      chk($sformatf("v%0d_result_hold", i), result, vecs[i].exp_result);
    end
    ovf_force = 1'b0;

    // Simultaneous requests: multiply wins.
    pulse(1'b1, 1'b1, 32'd3, 32'd4);
    chk("both_mult_sel", {31'd0, mult_sel}, 32'd1);
    wait_rdy(1, edges, maxc);
    chk("both_latency", edges, 18);
    chk("both_result", result, 32'd12);
    tick();

    // Abort a multiply at count 5 with a divide.
    pulse(1'b1, 1'b0, 32'd9, 32'd9);
    repeat (5) tick();
    chk("abort_count5", {26'd0, count}, 32'd5);
    pulse(1'b0, 1'b1, 32'd50, 32'd5);
    chk("abort_count0", {26'd0, count}, 32'd0);
    chk("abort_mult_sel", {31'd0, mult_sel}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    chk("abort_result_kept", result, 32'd12);
    wait_rdy(1, edges, maxc);
    chk("abort_latency", edges, 34);
    chk("abort_result", result, 32'd10);
    tick();

    // New request on the finishing cycle.
    pulse(1'b1, 1'b0, 32'd2, 32'd3);
    repeat (16) tick();
    chk("overlap_count16", {26'd0, count}, 32'd16);
    pulse(1'b0, 1'b1, 32'd20, 32'd4);
    chk("overlap_rdy", {31'd0, result_rdy}, 32'd1);
    chk("overlap_result", result, 32'd6);
    chk("overlap_busy", {31'd0, busy}, 32'd1);
    chk("overlap_count0", {26'd0, count}, 32'd0);
    chk("overlap_mult_sel", {31'd0, mult_sel}, 32'd0);
    tick();
    wait_rdy(2, edges, maxc);
    chk("overlap_div_latency", edges, 34);
    chk("overlap_div_result", result, 32'd5);
    tick();

    // Reset in the middle of a divide.
    pulse(1'b0, 1'b1, 32'd81, 32'd9);
    repeat (10) tick();
    chk("rst_mid_count10", {26'd0, count}, 32'd10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_count", {26'd0, count}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_result", result, 32'd0);
    chk("rst_mid_exc", {31'd0, exception}, 32'd0);
    rdy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (result_rdy) rdy_seen++;
      tick();
    end
    chk("rst_mid_no_rdy", rdy_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
